axi4lite_cmd_seq: RTL and testbench

AXI4LITE_CMD_SEQ -- requirements
Module: axi4lite_cmd_seq

---
 rtl/axi4lite_pkg.sv | 30 +++
 rtl/cmd_fifo.sv | 68 ++++++
 rtl/axi4lite_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_axi4lite_cmd_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi4lite_pkg
// Brief    : Shared encodings and default widths for the command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

    localparam int c_def_addr_w     = 2;
    localparam int c_def_data_w     = 8;
    localparam int c_def_fifo_depth = 4;
    localparam int c_def_timeout    = 255;

    localparam int c_state_w = 2;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle      = 2'd0;
    localparam state_t c_st_issue     = 2'd1;
    localparam state_t c_st_wait_done = 2'd2;

    localparam logic c_op_wr = 1'b0;
    localparam logic c_op_rd = 1'b1;

    // Occupancy counter must represent DEPTH itself, hence the extra bit.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous command FIFO; a push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo
    import axi4lite_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = c_def_fifo_depth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = fifo_cnt_w(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_cmd_seq
// Brief    : Turns asynchronous read/write request pins into queued commands
//            and sequences them onto an AXI4-Lite master start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module axi4lite_cmd_seq
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W     = c_def_addr_w,
    parameter int DATA_W     = c_def_data_w,
    parameter int FIFO_DEPTH = c_def_fifo_depth,
    parameter int TIMEOUT    = c_def_timeout
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              m_start_write,
    output logic [ADDR_W-1:0] m_write_addr,
    output logic [DATA_W-1:0] m_write_data,
    output logic              m_start_read,
    output logic [ADDR_W-1:0] m_read_addr,
    input  logic [DATA_W-1:0] m_read_data,
    input  logic              m_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [2:0]        status
);

    localparam int c_entry_w = 1 + ADDR_W + DATA_W;
    localparam int c_tmo_w   = $clog2(TIMEOUT + 1);

    // [0] metastability flop, [1] synchronised level, [2] previous level
    logic [2:0]           r_wr_sync;
    logic [2:0]           r_rd_sync;
    logic                 w_wr_rise;
    logic                 w_rd_rise;
    logic                 w_push_req;
    logic                 w_push_op;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;
    logic                 w_head_op;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    state_t               r_state;
    logic                 r_op;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic                 r_st_timeout;
    logic                 r_st_overflow;
    logic                 r_st_collision;

    assign w_wr_rise   = r_wr_sync[1] & ~r_wr_sync[2];
    assign w_rd_rise   = r_rd_sync[1] & ~r_rd_sync[2];
    assign w_push_req  = w_wr_rise | w_rd_rise;
    assign w_push_op   = w_wr_rise ? c_op_wr : c_op_rd;
    assign w_push_data = {w_push_op, req_addr, req_wdata};
    assign w_head_op   = w_head[c_entry_w-1];
    assign w_head_addr = w_head[DATA_W +: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_pop       = (r_state == c_st_idle) && !w_fifo_empty;
    assign busy        = (r_state != c_st_idle) || !w_fifo_empty;
    assign status      = {r_st_timeout, r_st_overflow, r_st_collision};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_sync <= '0;
            r_rd_sync <= '0;
        end else begin
            r_wr_sync <= {r_wr_sync[1:0], req_wr};
            r_rd_sync <= {r_rd_sync[1:0], req_rd};
        end
    end

    cmd_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_req),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // A read edge coinciding with a write edge is dropped by w_push_op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_overflow  <= 1'b0;
            r_st_collision <= 1'b0;
        end else begin
            if (w_wr_rise && w_rd_rise) begin
                r_st_collision <= 1'b1;
            end
            if (w_push_req && w_fifo_full && !w_pop) begin
                r_st_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_op          <= c_op_wr;
            r_tmo_cnt     <= '0;
            r_st_timeout  <= 1'b0;
            m_start_write <= 1'b0;
            m_start_read  <= 1'b0;
            m_write_addr  <= '0;
            m_write_data  <= '0;
            m_read_addr   <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
        end else begin
            m_start_write <= 1'b0;
            m_start_read  <= 1'b0;
            rd_valid      <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!w_fifo_empty) begin
                        r_op <= w_head_op;
                        if (w_head_op == c_op_wr) begin
                            m_write_addr <= w_head_addr;
                            m_write_data <= w_head_data;
                        end else begin
                            m_read_addr <= w_head_addr;
                        end
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_tmo_cnt     <= '0;
                    m_start_write <= (r_op == c_op_wr);
                    m_start_read  <= (r_op == c_op_rd);
                    r_state       <= c_st_wait_done;
                end
                c_st_wait_done: begin
                    if (m_done) begin
                        if (r_op == c_op_rd) begin
                            rd_data  <= m_read_data;
                            rd_valid <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end else if (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1)) begin
                        r_st_timeout <= 1'b1;
                        r_state      <= c_st_idle;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_cmd_seq
// Brief    : Self-checking bench with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_cmd_seq;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_wr = 1'b0;
    logic              req_rd = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0] m_read_data = '0;
    logic              m_done = 1'b0;
    logic              m_start_write;
    logic              m_start_read;
    logic [ADDR_W-1:0] m_write_addr;
    logic [DATA_W-1:0] m_write_data;
    logic [ADDR_W-1:0] m_read_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic [2:0]        status;

    always #5 clk = ~clk;

    axi4lite_cmd_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_wr        (req_wr),
        .req_rd        (req_rd),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .m_start_write (m_start_write),
        .m_write_addr  (m_write_addr),
        .m_write_data  (m_write_data),
        .m_start_read  (m_start_read),
        .m_read_addr   (m_read_addr),
        .m_read_data   (m_read_data),
        .m_done        (m_done),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy          (busy),
        .status        (status)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of pending commands plus one in-flight
    // command whose age (edges since it left the queue) decides its phase.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              mq[$];
    cmd_t              cur;
    cmd_t              newc;
    bit                inflight;
    int                age;
    logic [2:0]        samp_wr;
    logic [2:0]        samp_rd;
    bit                m_wrise;
    bit                m_rrise;
    bit                m_popnow;
    logic              e_sw, e_sr, e_rv, e_to, e_ovf, e_col;
    logic [ADDR_W-1:0] e_wa, e_ra;
    logic [DATA_W-1:0] e_wd, e_rd;

    always @(posedge clk or negedge rst_n) begin : p_model
        if (!rst_n) begin
            mq.delete();
            inflight = 1'b0;
            age      = 0;
            samp_wr  = '0;
            samp_rd  = '0;
            e_sw = 1'b0; e_sr = 1'b0; e_rv = 1'b0;
            e_to = 1'b0; e_ovf = 1'b0; e_col = 1'b0;
            e_wa = '0; e_ra = '0; e_wd = '0; e_rd = '0;
        end else begin
            // A pin level first seen at edge n is acted on at edge n+2.
            m_wrise  = samp_wr[1] && !samp_wr[2];
            m_rrise  = samp_rd[1] && !samp_rd[2];
            samp_wr  = {samp_wr[1:0], req_wr};
            samp_rd  = {samp_rd[1:0], req_rd};
            m_popnow = !inflight && (mq.size() > 0);
            e_sw = 1'b0; e_sr = 1'b0; e_rv = 1'b0;
            if (inflight) begin
                age++;
                if (age == 1) begin
                    e_sw = !cur.op;
                    e_sr = cur.op;
                end else if (m_done) begin
                    if (cur.op) begin
                        e_rd = m_read_data;
                        e_rv = 1'b1;
                    end
                    inflight = 1'b0;
                end else if (age == TIMEOUT + 1) begin
                    e_to     = 1'b1;
                    inflight = 1'b0;
                end
            end
            if (m_wrise || m_rrise) begin
                if (m_wrise && m_rrise) e_col = 1'b1;
                newc.op   = !m_wrise;
                newc.addr = req_addr;
                newc.data = req_wdata;
                if (mq.size() < FIFO_DEPTH || m_popnow) mq.push_back(newc);
                else e_ovf = 1'b1;
            end
            if (m_popnow) begin
                cur      = mq.pop_front();
                inflight = 1'b1;
                age      = 0;
                if (!cur.op) begin
                    e_wa = cur.addr;
                    e_wd = cur.data;
                end else begin
                    e_ra = cur.addr;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int wcnt    = 0;
    int rcnt    = 0;
    int rvcnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("m_start_write", 32'(m_start_write), 32'(e_sw));
        check("m_start_read",  32'(m_start_read),  32'(e_sr));
        check("m_write_addr",  32'(m_write_addr),  32'(e_wa));
        check("m_write_data",  32'(m_write_data),  32'(e_wd));
        check("m_read_addr",   32'(m_read_addr),   32'(e_ra));
        check("rd_data",       32'(rd_data),       32'(e_rd));
        check("rd_valid",      32'(rd_valid),      32'(e_rv));
        check("busy",          32'(busy),          32'(inflight || (mq.size() > 0)));
        check("status",        32'(status),        32'({e_to, e_ovf, e_col}));
        if (m_start_write === 1'b1) wcnt++;
        if (m_start_read === 1'b1)  rcnt++;
        if (rd_valid === 1'b1)      rvcnt++;
    endtask

    task automatic do_reset();
        req_wr = 1'b0;
        req_rd = 1'b0;
        m_done = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_pulse(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (m_start_write === 1'b1 || m_start_read === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Answers every start pulse with m_done in the following cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            m_done = (m_start_write === 1'b1) || (m_start_read === 1'b1);
        end
        m_done = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : p_stim
        bit ok;
        int first;
        int t_a;
        int t_b;

        do_reset();
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_status", 32'(status), 32'd0);

        // Single write: pulse lands 4 edges after the pin is first sampled.
        req_addr = 2'd2; req_wdata = 8'hA5; req_wr = 1'b1;
        wcnt = 0; first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (m_start_write === 1'b1 && first < 0) first = k;
        end
        check("t1_pulses",  32'(wcnt), 32'd1);
        check("t1_latency", 32'(first), 32'd5);
        check("t1_addr",    32'(m_write_addr), 32'd2);
        check("t1_data",    32'(m_write_data), 32'hA5);
        req_wr = 1'b0; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick(); tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Read returning 0x3C.
        req_addr = 2'd1; req_rd = 1'b1;
        wait_pulse(20, ok);
        check("t2_issue", 32'(ok), 32'd1);
        check("t2_raddr", 32'(m_read_addr), 32'd1);
        req_rd = 1'b0; m_read_data = 8'h3C; m_done = 1'b1; rvcnt = 0;
        tick();
        check("t2_rvalid", 32'(rd_valid), 32'd1);
        check("t2_rdata",  32'(rd_data), 32'h3C);
        m_done = 1'b0; m_read_data = 8'h00;
        repeat (4) tick();
        check("t2_rv_once", 32'(rvcnt), 32'd1);
        check("t2_hold",    32'(rd_data), 32'h3C);

        // Six writes with m_done withheld: 1 in flight, 4 queued, 1 dropped.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_addr = i[1:0]; req_wdata = 8'(8'h10 + i); req_wr = 1'b1;
            repeat (3) tick();
            req_wr = 1'b0;
            repeat (3) tick();
        end
        check("t3_status", 32'(status), 32'b010);
        check("t3_first",  32'(m_write_data), 32'h10);
        for (int k = 0; k < 4; k++) begin
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            wait_pulse(10, ok);
            check("t3_issue", 32'(ok), 32'd1);
            check("t3_order", 32'(m_write_data), 32'(8'h11 + k));
        end
        m_done = 1'b1;
        tick();
        m_done = 1'b0; wcnt = 0;
        repeat (10) tick();
        check("t3_no_sixth", 32'(wcnt), 32'd0);
        check("t3_idle",     32'(busy), 32'd0);

        // Simultaneous edges: only the write survives.
        do_reset();
        req_addr = 2'd3; req_wdata = 8'h5A; req_wr = 1'b1; req_rd = 1'b1;
        wcnt = 0; rcnt = 0;
        run(12);
        req_wr = 1'b0; req_rd = 1'b0;
        run(12);
        check("t4_writes", 32'(wcnt), 32'd1);
        check("t4_reads",  32'(rcnt), 32'd0);
        check("t4_status", 32'(status), 32'b001);
        check("t4_addr",   32'(m_write_addr), 32'd3);

        // Timeout: second queued write issues after the first gives up.
        do_reset();
        t_a = -1; t_b = -1;
        for (int k = 0; k < 300; k++) begin
            case (k)
                0: begin req_addr = 2'd1; req_wdata = 8'h11; req_wr = 1'b1; end
                3: req_wr = 1'b0;
                6: begin req_addr = 2'd2; req_wdata = 8'h22; req_wr = 1'b1; end
                9: req_wr = 1'b0;
                default: ;
            endcase
            tick();
            if (t_a >= 0 && k == t_a + 254) check("t5_pre_status", 32'(status), 32'b000);
            if (t_a >= 0 && k == t_a + 255) check("t5_status", 32'(status), 32'b100);
            if (m_start_write === 1'b1) begin
                if (t_a < 0) t_a = k;
                else if (t_b < 0) t_b = k;
            end
        end
        check("t5_second", 32'(t_b >= 0), 32'd1);
        check("t5_gap",    32'(t_b - t_a), 32'd257);
        check("t5_data",   32'(m_write_data), 32'h22);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick(); tick();
        check("t5_idle", 32'(busy), 32'd0);

        // Reset while a read waits; a late m_done must be ignored.
        do_reset();
        req_addr = 2'd2; req_rd = 1'b1;
        wait_pulse(20, ok);
        check("t6_issue", 32'(ok), 32'd1);
        req_rd = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("t6_outs", 32'({m_start_write, m_start_read, m_write_addr, m_write_data,
                              m_read_addr, rd_data, rd_valid}), 32'd0);
        check("t6_busy",   32'(busy), 32'd0);
        check("t6_status", 32'(status), 32'd0);
        rst_n = 1'b1; m_read_data = 8'hFF; m_done = 1'b1; rvcnt = 0; rcnt = 0;
        tick();
        m_done = 1'b0;
        repeat (5) tick();
        check("t6_no_rvalid", 32'(rvcnt), 32'd0);
        check("t6_no_start",  32'(rcnt), 32'd0);
        check("t6_rdata",     32'(rd_data), 32'd0);

        // Randomised traffic, with m_done starvation windows and stray resets.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) req_wr = ~req_wr;
            if ($urandom_range(0, 3) == 0) req_rd = ~req_rd;
            req_addr    = ADDR_W'($urandom);
            req_wdata   = DATA_W'($urandom);
            m_read_data = DATA_W'($urandom);
            m_done      = ((k % 1000) < 700) ? ($urandom_range(0, 5) == 0) : 1'b0;
            rst_n       = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
